// File: rtl/branch_pred_ctrl_if.sv
// Fetch/execute-side signal bundle for the branch predictor controller.
// The master drives lookups and resolves; the slave (the predictor) returns status.
interface branch_pred_ctrl_if;
    logic        lookup_valid;
    logic [63:0] lookup_pc;
    logic        pred_taken;
    logic        stall;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        mispredict;
    logic [2:0]  inflight;
    logic        resolve_err;
    logic [15:0] miss_cnt;

    modport master (
        output lookup_valid, lookup_pc, resolve_valid, resolve_taken,
        input  pred_taken, stall, mispredict, inflight, resolve_err, miss_cnt
    );

    modport slave (
        input  lookup_valid, lookup_pc, resolve_valid, resolve_taken,
        output pred_taken, stall, mispredict, inflight, resolve_err, miss_cnt
    );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Bimodal branch predictor: a table of 2-bit saturating counters plus an
// in-order queue of unresolved predictions that is flushed on a mispredict.
module branch_pred_ctrl #(
    parameter int IDX_W  = 4,
    parameter int QDEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    branch_pred_ctrl_if.slave  bp
);
    localparam int          ENTRIES = 1 << IDX_W;
    localparam int          PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [2:0]  DEPTH_C = 3'(QDEPTH);
    localparam logic [1:0]  CTR_ST  = 2'd2;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        r = ctr;
        if (taken) begin
            if (ctr != 2'd3) r = ctr + 2'd1;
            else             r = ctr;
        end else begin
            if (ctr != 2'd0) r = ctr - 2'd1;
            else             r = ctr;
        end
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(QDEPTH - 1)) r = '0;
        else                         r = p + PTR_W'(1);
        return r;
    endfunction

    logic [1:0]       table_q     [ENTRIES];
    logic [IDX_W-1:0] fifo_idx_q  [QDEPTH];
    logic             fifo_pred_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             mispredict_q, mispredict_d;
    logic             resolve_err_q, resolve_err_d;
    logic [15:0]      miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] lk_idx_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             head_pred_s;
    logic             pred_s;
    logic             stall_s;
    logic             push_s;
    logic             pop_s;
    logic             miss_s;
    logic             fifo_we_s;
    logic             pc_unused_s;

    // Only the word-aligned index bits of the PC select a counter.
    assign pc_unused_s = ^{bp.lookup_pc[63:IDX_W+2], bp.lookup_pc[1:0]};

    // Lookup, queue control and next-state computation.
    always_comb begin
        lk_idx_s    = bp.lookup_pc[IDX_W+1:2];
        if (bp.lookup_valid) pred_s = table_q[lk_idx_s][1];
        else                 pred_s = 1'b0;
        stall_s     = (cnt_q == DEPTH_C);
        push_s      = bp.lookup_valid && !stall_s;
        pop_s       = bp.resolve_valid && (cnt_q != 3'd0);
        head_idx_s  = fifo_idx_q[rd_ptr_q];
        head_pred_s = fifo_pred_q[rd_ptr_q];
        miss_s      = pop_s && (bp.resolve_taken != head_pred_s);
        fifo_we_s   = push_s && !miss_s;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (miss_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = 3'd0;
        end else begin
            if (push_s) wr_ptr_d = ptr_next(wr_ptr_q);
            else        wr_ptr_d = wr_ptr_q;
            if (pop_s)  rd_ptr_d = ptr_next(rd_ptr_q);
            else        rd_ptr_d = rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + 3'd1;
                2'b01:   cnt_d = cnt_q - 3'd1;
                default: cnt_d = cnt_q;
            endcase
        end

        mispredict_d = miss_s;
        if (miss_s && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
        else                                    miss_cnt_d = miss_cnt_q;
        if (bp.resolve_valid && (cnt_q == 3'd0)) resolve_err_d = 1'b1;
        else                                     resolve_err_d = resolve_err_q;
    end

    // State registers; table update uses the pre-edge counter so a same-cycle lookup sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            table_q       <= '{default: CTR_ST};
            fifo_idx_q    <= '{default: '0};
            fifo_pred_q   <= '{default: 1'b0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= 3'd0;
            mispredict_q  <= 1'b0;
            resolve_err_q <= 1'b0;
            miss_cnt_q    <= 16'd0;
        end else begin
            if (pop_s) table_q[head_idx_s] <= ctr_next(table_q[head_idx_s], bp.resolve_taken);
            if (fifo_we_s) begin
                fifo_idx_q[wr_ptr_q]  <= lk_idx_s;
                fifo_pred_q[wr_ptr_q] <= pred_s;
            end
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            mispredict_q  <= mispredict_d;
            resolve_err_q <= resolve_err_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign bp.pred_taken  = pred_s;
    assign bp.stall       = stall_s;
    assign bp.mispredict  = mispredict_q;
    assign bp.inflight    = cnt_q;
    assign bp.resolve_err = resolve_err_q;
    assign bp.miss_cnt    = miss_cnt_q;
endmodule

// File: doc/branch_pred_ctrl.md
BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning log2 of the number of prediction-table entries (16).
REQ-002 SHALL have parameter QDEPTH, default 4, meaning the maximum number of in-flight unresolved predictions.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port lookup_valid, input, 1 bit: the fetch stage presents a conditional branch for prediction.
REQ-006 SHALL have port lookup_pc, input, 64 bits: the branch instruction address.
REQ-007 SHALL have port pred_taken, output, 1 bit: the prediction for lookup_pc (combinational).
REQ-008 SHALL have port stall, output, 1 bit: the in-flight queue is full and fetch must hold.
REQ-009 SHALL have port resolve_valid, input, 1 bit: the execute stage resolves the oldest in-flight branch.
REQ-010 SHALL have port resolve_taken, input, 1 bit: the actual branch outcome.
REQ-011 SHALL have port mispredict, output, 1 bit: a registered one-cycle flush pulse.
REQ-012 SHALL have port inflight, output, 3 bits: the current queue occupancy (0..QDEPTH).
REQ-013 SHALL have port resolve_err, output, 1 bit: a sticky flag set on a resolve while the queue is empty.
REQ-014 SHALL have port miss_cnt, output, 16 bits: the mispredict count, saturating at 0xFFFF.

Function
REQ-015 SHALL hold a table of 2^IDX_W 2-bit saturating counters with states af=0, sf=1, st=2, at=3.
REQ-016 SHALL index the table with idx = lookup_pc[IDX_W+1:2], ignoring the word-offset bits.
REQ-017 SHALL drive pred_taken = table[idx][1] when lookup_valid=1, and 0 otherwise.
REQ-018 SHALL implement the in-flight queue as an in-order FIFO of {idx, pred} entries with wrapping read/write pointers mod QDEPTH.
REQ-019 SHALL push a lookup on the clock edge where lookup_valid=1 and inflight<QDEPTH.
REQ-020 SHALL drive stall = (inflight==QDEPTH) combinationally and drop a lookup made while full, even if a resolve pops in the same cycle.
REQ-021 SHALL, on resolve_valid=1 with inflight>0, pop the head entry and update table[head.idx]: taken increments (saturating at 3), not-taken decrements (saturating at 0).
REQ-022 SHALL treat resolve_taken != head.pred as a mispredict: clear the FIFO at that edge (all younger entries and any same-cycle push discarded, inflight=0) and assert mispredict=1 for the following cycle only.
REQ-023 SHALL apply the table update on a mispredict identically to a correct prediction.
REQ-024 SHALL increment miss_cnt once per mispredict, saturating at 0xFFFF.
REQ-025 SHALL, on a resolve with no mispredict and a same-cycle accepted push, leave inflight unchanged and advance both pointers.
REQ-026 SHALL, on simultaneous lookup and resolve to the same table index, return the pre-update counter value for pred_taken and enqueue that value.
REQ-027 SHALL ignore a resolve_valid=1 when inflight==0 (no table change, no mispredict) and set resolve_err=1 until reset; a same-cycle lookup still pushes.
REQ-028 SHALL perform all updates in a single cycle, with no multi-cycle operations.

Reset
REQ-029 SHALL, while reset=0, asynchronously set every table entry to st (2), clear both pointers, and set inflight=0, mispredict=0, resolve_err=0, miss_cnt=0.
REQ-030 SHALL, on reset asserted mid-operation, discard all in-flight entries with no mispredict pulse on release.
REQ-031 SHALL resume normal operation on the first posedge after reset deasserts.

Verification
REQ-032 Bench SHALL cover reset then lookup pc=0x40 -> pred_taken=1, inflight=1; resolve taken=1 -> mispredict=0, table[0] becomes 3.
REQ-033 Bench SHALL cover three not-taken resolves at pc=0x40 starting from state 2 -> first resolve mispredicts; states 1, 0, 0; final lookup pred_taken=0; miss_cnt=1.
REQ-034 Bench SHALL cover 5 consecutive lookups with no resolves -> stall=1 after the 4th, 5th lookup dropped, inflight=4; one correct resolve -> inflight=3, stall=0.
REQ-035 Bench SHALL cover 3 in flight followed by a mispredicting resolve plus a same-cycle lookup -> inflight=0 next cycle, mispredict high exactly one cycle.
REQ-036 Bench SHALL cover resolve_valid with an empty queue -> resolve_err=1, table unchanged; it stays set until reset=0.
REQ-037 Bench SHALL cover reset=0 asserted between clock edges with 2 in flight -> outputs clear immediately; after release inflight=0 and all predictions=1.
